// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter and its users.
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W      = 5;
  localparam int RF_DATA_W      = 32;
  localparam int RF_REG_NUM     = 32;
  localparam int RF_REG_NUM_LOG2 = 5;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans req from ptr upward and grants the first valid
// requester; generic so it can be reused for memory-port arbitration.
module rr_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic found;
  int   scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = (int'(ptr) + off) % NUM_REQ;
      // Constant-index inner loop keeps every bit select static.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en && !found && (i == scan_idx) && req[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port among NUM_REQ writeback sources with a
// round-robin grant, one registered output stage and a RAW pending mask.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W,
  parameter int REG_NUM = RF_REG_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic [REG_NUM-1:0]        pending
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               arb_en;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  assign arb_en = (rst != RST_ENABLE) && !hold;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // grant is already qualified by req_valid, so any grant bit is a transfer.
  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_waddr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    we_d     = WRITE_DISABLE;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      // x0 writes still consume the grant but never assert we.
      we_d     = (sel_addr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
      waddr_d  = sel_addr;
      wdata_d  = sel_data;
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      we_q     <= WRITE_DISABLE;
      waddr_q  <= '0;
      wdata_q  <= ZERO_WORD[DATA_W-1:0];
      rr_ptr_q <= '0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  always_comb begin
    pending = '0;
    for (int k = 1; k < REG_NUM; k++) begin
      pending[k] = we_q && (waddr_q == ADDR_W'(k));
      for (int i = 0; i < NUM_REQ; i++) begin
        pending[k] = pending[k] |
                     (req_valid[i] && (req_waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(k)));
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table with hand-derived
// grants plus a scoreboard of expected write-port values one cycle later.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [1:0]  req_valid;
  logic [9:0]  req_waddr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pending;

  rf_write_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (5),
    .DATA_W  (32),
    .REG_NUM (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic [1:0]  valid;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } out_t;

  vec_t vecs[$];
  out_t sb_q[$];
  out_t last_out;
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, input logic h, input logic [1:0] v,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [1:0] er);
    vec_t t;
    t.rst = r; t.hold = h; t.valid = v;
    t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
    t.exp_ready = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    out_t        e;
    out_t        n;
    logic [31:0] exp_pend;
    @(posedge clk);
    #1;
    rst       = v.rst;
    hold      = v.hold;
    req_valid = v.valid;
    req_waddr = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    @(negedge clk);
    check("req_ready", {30'd0, req_ready}, {30'd0, v.exp_ready});
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected >=1", $time);
      e = last_out;
    end else begin
      e = sb_q.pop_front();
      check("we", {31'd0, we}, {31'd0, e.we});
      check("waddr", {27'd0, waddr}, {27'd0, e.addr});
      check("wdata", wdata, e.data);
    end
    exp_pend = '0;
    for (int k = 1; k < 32; k++) begin
      exp_pend[k] = (e.we && e.addr == 5'(k)) ||
                    (v.valid[0] && v.a0 == 5'(k)) ||
                    (v.valid[1] && v.a1 == 5'(k));
    end
    check("pending", pending, exp_pend);
    if (v.rst)               n = '{1'b0, 5'd0, 32'd0};
    else if (v.exp_ready[0]) n = '{(v.a0 != 5'd0), v.a0, v.d0};
    else if (v.exp_ready[1]) n = '{(v.a1 != 5'd0), v.a1, v.d1};
    else                     n = '{1'b0, last_out.addr, last_out.data};
    sb_q.push_back(n);
    last_out = n;
  endtask

  initial begin
    vec_t        v;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;

    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = 2'b11;
    req_waddr = '0;
    req_wdata = '0;
    last_out  = '{1'b0, 5'd0, 32'd0};
    sb_q.push_back(last_out);

    // reset with both requesters valid
    repeat (3) vecs.push_back(mk(1, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b00));
    // both valid from reset: strict alternation starting at req0
    vecs.push_back(mk(0, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b01));
    vecs.push_back(mk(0, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b10));
    vecs.push_back(mk(0, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b01));
    vecs.push_back(mk(0, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b10));
    // grant req0, hold two cycles, release goes to req1
    vecs.push_back(mk(0, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b01));
    vecs.push_back(mk(0, 1, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b00));
    vecs.push_back(mk(0, 1, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b00));
    vecs.push_back(mk(0, 0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b10));
    // single write to x5, then idle
    vecs.push_back(mk(0, 0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01));
    vecs.push_back(mk(0, 0, 2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00));
    // x0 write from req1, pointer must wrap back to req0
    vecs.push_back(mk(0, 0, 2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 2'b10));
    vecs.push_back(mk(0, 0, 2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 2'b01));
    // reset while req0 valid; pointer returns to 0 afterwards
    vecs.push_back(mk(1, 0, 2'b01, 5'd7, 32'h77, 5'd4, 32'h44, 2'b00));
    vecs.push_back(mk(0, 0, 2'b11, 5'd7, 32'h77, 5'd8, 32'h88, 2'b01));
    vecs.push_back(mk(0, 0, 2'b10, 5'd7, 32'h77, 5'd8, 32'h88, 2'b10));
    // same address from both requesters, RR order, req1 commits last
    vecs.push_back(mk(0, 0, 2'b11, 5'd9, 32'h90, 5'd9, 32'h91, 2'b01));
    vecs.push_back(mk(0, 0, 2'b10, 5'd9, 32'h90, 5'd9, 32'h91, 2'b10));
    vecs.push_back(mk(0, 0, 2'b00, 5'd9, 32'h90, 5'd9, 32'h91, 2'b00));
    vecs.push_back(mk(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00));

    foreach (vecs[i]) apply(vecs[i]);

    // Fairness run: both valid continuously with fresh payloads after each
    // grant; pointer is 0 here, so grants alternate starting with req0.
    fa0 = 5'(1 + $urandom_range(0, 30)); fd0 = $urandom;
    fa1 = 5'(1 + $urandom_range(0, 30)); fd1 = $urandom;
    for (int c = 0; c < 10; c++) begin
      v = mk(0, 0, 2'b11, fa0, fd0, fa1, fd1, (c % 2 == 0) ? 2'b01 : 2'b10);
      apply(v);
      if (c % 2 == 0) begin
        fa0 = 5'(1 + $urandom_range(0, 30)); fd0 = $urandom;
      end else begin
        fa1 = 5'(1 + $urandom_range(0, 30)); fd1 = $urandom;
      end
    end
    // drain the output stage
    apply(mk(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00));
    apply(mk(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
